tick_pwm_generator: RTL and testbench

Tick-driven PWM generator that sits directly downstream of the general-purpose clock divider. It consumes the divider's single-cycle terminal-count pulse as a clock enable (`tick_in`) and produces a registered PWM waveform with programmable period and duty, both measured in ticks. New period/duty values are accepted over a valid/ready handshake into shadow registers and applied only at a period boundary, so the output never shows a truncated or torn cycle.

---
 rtl/tick_pwm_generator_if.sv | 24 ++
 rtl/tick_pwm_generator.sv | 137 +++++++++++++
 tb/tb_tick_pwm_generator.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_pwm_generator_if.sv
// Configuration handshake between a PWM controller and tick_pwm_generator:
// a new period/duty pair offered with valid/ready.
interface tick_pwm_generator_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_duty;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_duty,
        output cfg_ready
    );
endinterface

// File: rtl/tick_pwm_generator.sv
// Tick-enabled PWM generator with shadowed period/duty applied only at period boundaries.
// Optional feature macro: PWM_PERIOD_DONE_EN adds the period_done pulse output.
module tick_pwm_generator #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_in,
    input  logic                 enable,
    tick_pwm_generator_if.slave  cfg,
    output logic                 pwm_out,
`ifdef PWM_PERIOD_DONE_EN
    output logic                 period_done,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(15);
    localparam logic [WIDTH-1:0] RST_DUTY   = WIDTH'(8);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_sh_q, period_sh_d;
    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;
    logic             running;
    logic             wrap;
    logic             xfer;
    logic             apply;

    assign running = (state_q != IDLE);
    // Period 0 wraps after 2^WIDTH ticks because the subtraction is modulo 2^WIDTH.
    assign wrap    = running && tick_in && (cnt_q == (period_act_q - ONE));
    assign xfer    = cfg.cfg_valid && !pending_q;

    // State register and all datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_sh_q  <= RST_PERIOD;
            duty_sh_q    <= RST_DUTY;
            period_act_q <= RST_PERIOD;
            duty_act_q   <= RST_DUTY;
            pending_q    <= 1'b0;
            pwm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_sh_q  <= period_sh_d;
            duty_sh_q    <= duty_sh_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            pending_q    <= pending_d;
            pwm_q        <= pwm_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable)    state_d = RUN;
                else if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter, shadow/active configuration and the registered PWM level.
    always_comb begin
        cnt_d = cnt_q;
        apply = 1'b0;
        if (!running) begin
            // A tick coinciding with the start edge is deliberately dropped.
            cnt_d = '0;
            apply = enable && pending_q;
        end else begin
            if (tick_in) cnt_d = wrap ? '0 : (cnt_q + ONE);
            apply = wrap && pending_q;
        end

        period_act_d = apply ? period_sh_q : period_act_q;
        duty_act_d   = apply ? duty_sh_q   : duty_act_q;
        period_sh_d  = xfer ? cfg.cfg_period : period_sh_q;
        duty_sh_d    = xfer ? cfg.cfg_duty   : duty_sh_q;
        // apply needs pending_q=1 and xfer needs pending_q=0, so they never collide.
        pending_d    = xfer || (pending_q && !apply);

        pwm_d = (state_d != IDLE) && (cnt_d < duty_act_d);
    end

    // Output decode.
    always_comb begin
        busy          = running;
        cfg.cfg_ready = !pending_q;
        pwm_out       = pwm_q;
    end

`ifdef PWM_PERIOD_DONE_EN
    logic period_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) period_done_q <= 1'b0;
        else     period_done_q <= wrap;
    end

    assign period_done = period_done_q;
`endif

`ifndef SYNTHESIS
    a_pwm_only_when_busy: assert property (
        @(posedge clk) disable iff (rst) pwm_q |-> running);
    a_idle_cnt_zero: assert property (
        @(posedge clk) disable iff (rst) (state_q == IDLE) |-> (cnt_q == '0));
    a_cnt_in_period: assert property (
        @(posedge clk) disable iff (rst) (period_act_q != '0) |-> (cnt_q < period_act_q));
`endif

endmodule

// File: tb/tb_tick_pwm_generator.sv
// Scoreboard bench for tick_pwm_generator: a cycle model pushes expected outputs per edge,
// each scenario task pops and compares them plus hand-derived waveform constants.
module tb_tick_pwm_generator;

    localparam int WIDTH = 8;
`ifdef PWM_PERIOD_DONE_EN
    localparam bit PD = 1'b1;
`else
    localparam bit PD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tick_in;
    logic enable;
    logic pwm_out;
    logic busy;
    logic period_done;

    tick_pwm_generator_if #(.WIDTH(WIDTH)) ifc ();

    tick_pwm_generator #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .enable      (enable),
        .cfg         (ifc),
        .pwm_out     (pwm_out),
`ifdef PWM_PERIOD_DONE_EN
        .period_done (period_done),
`endif
        .busy        (busy)
    );

`ifndef PWM_PERIOD_DONE_EN
    assign period_done = 1'b0;
`endif

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model state; periods are kept as effective tick counts (1..256).
    int         m_state;
    int         m_cnt;
    int         m_pact, m_dact, m_psh, m_dsh;
    bit         m_pend;
    logic [3:0] sb_q[$];

    function automatic int eff(input logic [7:0] v);
        return (v == 8'd0) ? 256 : int'(v);
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_pend = 1'b0;
        m_pact = 15; m_dact = 8; m_psh = 15; m_dsh = 8;
        sb_q.delete();
    endtask

    // Evaluate one rising edge with the inputs currently driven; push {pwm,busy,ready,done}.
    task automatic model_edge();
        bit wr, xf, ap;
        int ns;
        wr = (m_state != 0) && tick_in && (m_cnt == m_pact - 1);
        xf = ifc.cfg_valid && !m_pend;
        ap = 1'b0;
        ns = m_state;
        if (m_state == 0) begin
            if (enable) begin ns = 1; ap = m_pend; end
        end else begin
            ap = wr && m_pend;
            if (tick_in) m_cnt = wr ? 0 : m_cnt + 1;
            if (m_state == 1 && !enable) ns = 2;
            else if (m_state == 2) ns = enable ? 1 : (wr ? 0 : 2);
        end
        if (ap) begin m_pact = m_psh; m_dact = m_dsh; m_pend = 1'b0; end
        if (xf) begin m_psh = eff(ifc.cfg_period); m_dsh = int'(ifc.cfg_duty); m_pend = 1'b1; end
        m_state = ns;
        sb_q.push_back({(ns != 0) && (m_cnt < m_dact), ns != 0, !m_pend, PD && wr});
    endtask

    task automatic cyc(input bit t, input bit e);
        tick_in = t;
        enable  = e;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] p, input logic [7:0] d);
        ifc.cfg_valid  = 1'b1;
        ifc.cfg_period = p;
        ifc.cfg_duty   = d;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({pwm_out, busy, ifc.cfg_ready, period_done} !== 4'b0010) begin
            failed++;
            $display("FAIL reset_vals got=%b exp=0010", {pwm_out, busy, ifc.cfg_ready, period_done});
        end
        @(posedge clk); #1;
        tests++;
        if ({pwm_out, busy, ifc.cfg_ready, period_done} !== 4'b0010) begin
            failed++;
            $display("FAIL reset_held got=%b exp=0010", {pwm_out, busy, ifc.cfg_ready, period_done});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0] got, exp;
        for (int i = 0; i < 45; i++) begin
            cyc(1'b1, 1'b1);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL basic_sb i=%0d got=%b exp=%b", i, got, exp);
            end
            tests++;
            if (got[3:1] !== {((i % 15) < 8), 2'b11}) begin
                failed++; $display("FAIL basic_wave i=%0d got=%b exp=%b", i, got[3:1], {((i % 15) < 8), 2'b11});
            end
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL basic_stop i=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_cfg_boundary();
        logic [3:0] got, exp;
        offer(8'd4, 8'd1);
        cyc(1'b0, 1'b0);
        ifc.cfg_valid = 1'b0;
        exp = sb_q.pop_front();
        tests++;
        if (ifc.cfg_ready !== 1'b0 || exp[1] !== 1'b0) begin
            failed++; $display("FAIL cfg_idle_ready got=%b exp=0", ifc.cfg_ready);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL cfg_p4 i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        for (int j = 0; j < 20; j++) begin
            if (j == 0) offer(8'd6, 8'd3);
            cyc(1'b1, 1'b1);
            ifc.cfg_valid = 1'b0;
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL cfg_sb j=%0d got=%b exp=%b", j, got, exp);
            end
            tests++;
            if (j < 2 ? (got[3] !== 1'b0 || got[1] !== 1'b0)
                      : (got[3] !== (((j - 2) % 6) < 3) || got[1] !== 1'b1)) begin
                failed++; $display("FAIL cfg_wave j=%0d got pwm=%b ready=%b", j, got[3], got[1]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL cfg_stop i=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_extreme_duty();
        logic [3:0] got, exp;
        offer(8'd5, 8'd0);
        cyc(1'b0, 1'b0);
        ifc.cfg_valid = 1'b0;
        void'(sb_q.pop_front());
        for (int i = 0; i < 40; i++) begin
            cyc((i % 3) == 0, 1'b1);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp || got[3:2] !== 2'b01) begin
                failed++; $display("FAIL duty0 i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        for (int i = 0; i < 60; i++) begin
            if (i == 0) offer(8'd5, 8'd9);
            cyc((i % 3) == 0, 1'b1);
            ifc.cfg_valid = 1'b0;
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp || (i >= 30 && got[3:2] !== 2'b11)) begin
                failed++; $display("FAIL duty_full i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        for (int i = 0; i < 1700; i++) begin
            if (i == 0) offer(8'd0, 8'd128);
            cyc((i % 3) == 0, 1'b1);
            ifc.cfg_valid = 1'b0;
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL period256 i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        for (int i = 0; i < 800; i++) begin
            cyc((i % 3) == 0, 1'b0);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL period256_stop i=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_drain();
        logic [3:0] got, exp;
        offer(8'd6, 8'd3);
        cyc(1'b0, 1'b0);
        ifc.cfg_valid = 1'b0;
        void'(sb_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1);
            void'(sb_q.pop_front());
        end
        for (int j = 0; j < 8; j++) begin
            cyc(1'b1, 1'b0);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL drain_sb j=%0d got=%b exp=%b", j, got, exp);
            end
            tests++;
            if (got[3:2] !== {1'b0, (j < 3)}) begin
                failed++; $display("FAIL drain_busy j=%0d got=%b exp=%b", j, got[3:2], {1'b0, (j < 3)});
            end
        end
        for (int n = 0; n < 20; n++) begin
            cyc(1'b1, n != 3);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp || got[3:2] !== {((n % 6) < 3), 1'b1}) begin
                failed++; $display("FAIL drain_resume n=%0d got=%b exp=%b", n, got, exp);
            end
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL drain_stop i=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] got, exp;
        offer(8'd4, 8'd1);
        cyc(1'b0, 1'b0);
        ifc.cfg_valid = 1'b0;
        void'(sb_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp || got[3] !== (i == 0)) begin
                failed++; $display("FAIL start_tick i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        for (int j = 0; j < 13; j++) begin
            if (j == 0) offer(8'd6, 8'd1);
            cyc(1'b1, 1'b1);
            ifc.cfg_valid = 1'b0;
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL wrap_cfg_sb j=%0d got=%b exp=%b", j, got, exp);
            end
            tests++;
            if (j < 4 ? (got[3] !== (j == 0) || got[1] !== 1'b0)
                      : (got[3] !== (((j - 4) % 6) == 0) || got[1] !== 1'b1)) begin
                failed++; $display("FAIL wrap_cfg_wave j=%0d got pwm=%b ready=%b", j, got[3], got[1]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL wrap_cfg_stop i=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] got, exp;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            pulses += int'(period_done);
            tests++;
            if (got !== exp || got[0] !== (PD && i > 0 && (i % 6) == 0)) begin
                failed++; $display("FAIL prerst i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        tests++;
        if (pulses !== (PD ? 2 : 0)) begin
            failed++; $display("FAIL done_count got=%0d exp=%0d", pulses, PD ? 2 : 0);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({pwm_out, busy, ifc.cfg_ready, period_done} !== 4'b0010) begin
            failed++; $display("FAIL async_rst got=%b exp=0010", {pwm_out, busy, ifc.cfg_ready, period_done});
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick_in = 1'b1; enable = 1'b1;
            @(posedge clk); #1;
            tests++;
            if ({pwm_out, busy, ifc.cfg_ready, period_done} !== 4'b0010) begin
                failed++; $display("FAIL in_rst i=%0d got=%b exp=0010", i, {pwm_out, busy, ifc.cfg_ready, period_done});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1);
            got = {pwm_out, busy, ifc.cfg_ready, period_done};
            exp = sb_q.pop_front();
            tests++;
            if (got !== exp) begin
                failed++; $display("FAIL postrst i=%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        tick_in        = 1'b0;
        enable         = 1'b0;
        ifc.cfg_valid  = 1'b0;
        ifc.cfg_period = '0;
        ifc.cfg_duty   = '0;
        model_reset();
        test_reset();
        test_basic();
        test_cfg_boundary();
        test_extreme_duty();
        test_drain();
        test_simultaneous();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
